// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel pipeline: default image geometry and pixel width,
// plus the 3x3 window slot mapping used by every stage.
package sobel_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int WIN_SLOTS = 9;

  // Slot of row i (0 oldest) and column j (0 leftmost) inside the packed window.
  function automatic int slot_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/line_window_3x3_line_ram.sv
// One row of pixel storage: write on the rising edge, read is taken from the
// stored array so a read and write to the same address in one cycle see old data.
module line_ram
  import sobel_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int WIDTH = PIX_W_DEF
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the incoming pixel; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[addr];

endmodule

// File: rtl/line_window_3x3.sv
// Raster-order 3x3 window generator: two line buffers feed a shifting column
// register; a window is flagged valid only when all nine taps belong to this frame.
module line_window_3x3
  import sobel_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic [PIX_W-1:0]             pixel_in,
  output logic                         valid_out,
  output logic [WIN_SLOTS*PIX_W-1:0]   window_out,
  output logic                         frame_end
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  logic [COL_W-1:0]               col_r;
  logic [ROW_W-1:0]               row_r;
  logic                           valid_r;
  logic                           frame_end_r;
  logic [WIN_SLOTS*PIX_W-1:0]     window_r;
  logic [WIN_SLOTS*PIX_W-1:0]     window_next_s;
  logic [PIX_W-1:0]               lb0_rd_s;
  logic [PIX_W-1:0]               lb1_rd_s;
  logic                           accept_s;
  logic                           col_last_s;
  logic                           row_last_s;
  logic                           win_ok_s;

  // Reset wins over an incoming pixel, so the buffers are not written during rst.
  assign accept_s   = valid_in & ~rst;
  assign col_last_s = (col_r == COL_LAST);
  assign row_last_s = (row_r == ROW_LAST);
  assign win_ok_s   = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));

  // LB1 holds the previous row; its old entry cascades into LB0 (two rows back).
  line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb0 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (col_r),
    .wr_data (lb1_rd_s),
    .rd_data (lb0_rd_s)
  );

  line_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk     (clk),
    .en      (accept_s),
    .addr    (col_r),
    .wr_data (pixel_in),
    .rd_data (lb1_rd_s)
  );

  // Shift the window one column left and load the new right-hand column.
  always_comb begin
    window_next_s = window_r;
    for (int i = 0; i < 3; i++) begin
      window_next_s[PIX_W*slot_idx(i, 0) +: PIX_W] = window_r[PIX_W*slot_idx(i, 1) +: PIX_W];
      window_next_s[PIX_W*slot_idx(i, 1) +: PIX_W] = window_r[PIX_W*slot_idx(i, 2) +: PIX_W];
    end
    window_next_s[PIX_W*slot_idx(0, 2) +: PIX_W] = lb0_rd_s;
    window_next_s[PIX_W*slot_idx(1, 2) +: PIX_W] = lb1_rd_s;
    window_next_s[PIX_W*slot_idx(2, 2) +: PIX_W] = pixel_in;
  end

  // Raster position of the pixel being accepted this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r <= {COL_W{1'b0}};
      row_r <= {ROW_W{1'b0}};
    end else if (valid_in) begin
      if (col_last_s) begin
        col_r <= {COL_W{1'b0}};
        row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
      end else begin
        col_r <= col_r + COL_W'(1);
      end
    end
  end

  // Window and flag registers; stale line-buffer data is masked by win_ok_s.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r     <= 1'b0;
      frame_end_r <= 1'b0;
      window_r    <= {(WIN_SLOTS*PIX_W){1'b0}};
    end else begin
      valid_r     <= valid_in & win_ok_s;
      frame_end_r <= valid_in & col_last_s & row_last_s;
      if (valid_in) begin
        window_r <= window_next_s;
      end
    end
  end

  assign valid_out  = valid_r;
  assign frame_end  = frame_end_r;
  assign window_out = window_r;

endmodule

// File: tb/tb_line_window_3x3.sv
// Directed bench for line_window_3x3 on a 4x4 image: ramp frames, gapped input,
// back-to-back frames and mid-frame reset, checked against hand/closed-form windows.
module tb_line_window_3x3;

  localparam int W = 4;
  localparam int H = 4;
  localparam int P = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid_in;
  logic [P-1:0]   pixel_in;
  logic           valid_out;
  logic           frame_end;
  logic [9*P-1:0] window_out;

  int          n_cmp = 0;
  int          n_err = 0;
  int          pulses;
  bit          have_last;
  logic [71:0] last_win;
  logic [71:0] first_obs;
  logic [71:0] last_obs;

  line_window_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .pixel_in   (pixel_in),
    .valid_out  (valid_out),
    .window_out (window_out),
    .frame_end  (frame_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window for acceptance of pixel (r,c): slot 3i+j = pixel (r-2+i, c-2+j).
  function automatic logic [71:0] exp_win(input logic [7:0] base, input int r, input int c);
    logic [71:0] w;
    w = 72'h0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = base + 8'(16*(r-2+i) + (c-2+j));
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid_in = 1'b1;
    pixel_in = 8'hFF;
    @(posedge clk); #1;
    chk("rst_valid", 72'(valid_out), 72'h0);
    chk("rst_fend", 72'(frame_end), 72'h0);
    chk("rst_window", 72'(window_out), 72'h0);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    have_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_valid", 72'(valid_out), 72'h0);
    if (have_last) chk("idle_hold", 72'(window_out), last_win);
  endtask

  task automatic send_px(input logic [7:0] base, input int r, input int c);
    logic [71:0] ew;
    bit ev;
    @(negedge clk);
    valid_in = 1'b1;
    pixel_in = base + 8'(16*r + c);
    @(posedge clk); #1;
    ev = (r >= 2) && (c >= 2);
    chk("valid_out", 72'(valid_out), 72'(ev));
    chk("frame_end", 72'(frame_end), 72'((r == H-1) && (c == W-1)));
    if (ev) begin
      ew = exp_win(base, r, c);
      chk("window", 72'(window_out), ew);
      if (pulses == 0) first_obs = 72'(window_out);
      last_obs  = 72'(window_out);
      last_win  = ew;
      have_last = 1'b1;
      pulses++;
    end else begin
      have_last = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] base, input bit gap, input int max_px);
    int n;
    n = 0;
    pulses = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (n < max_px) begin
          if (gap) idle_cycle();
          send_px(base, r, c);
          n++;
        end
  endtask

  initial begin
    rst = 1'b1;
    valid_in = 1'b0;
    pixel_in = 8'h00;
    have_last = 1'b0;
    pulses = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Continuous ramp frame followed immediately by a second, offset frame.
    send_frame(8'h00, 1'b0, W*H);
    chk("A_pulses", 72'(pulses), 72'd4);
    chk("A_first", first_obs, 72'h22_21_20_12_11_10_02_01_00);
    chk("A_last", last_obs, 72'h33_32_31_23_22_21_13_12_11);
    send_frame(8'h80, 1'b0, W*H);
    chk("B_pulses", 72'(pulses), 72'd4);
    chk("B_first", first_obs, 72'hA2_A1_A0_92_91_90_82_81_80);

    // Same ramp with an idle cycle before every pixel.
    send_frame(8'h00, 1'b1, W*H);
    chk("gap_pulses", 72'(pulses), 72'd4);
    chk("gap_first", first_obs, 72'h22_21_20_12_11_10_02_01_00);
    chk("gap_last", last_obs, 72'h33_32_31_23_22_21_13_12_11);

    // Abort after pixel 0x21, then a complete frame.
    send_frame(8'h00, 1'b0, 10);
    chk("part_pulses", 72'(pulses), 72'd0);
    do_reset();
    send_frame(8'h00, 1'b0, W*H);
    chk("rst_pulses", 72'(pulses), 72'd4);
    chk("rst_first", first_obs, 72'h22_21_20_12_11_10_02_01_00);

    @(negedge clk);
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
